irq_controller: RTL and testbench
=================================

// Module: irq_controller
// PURPOSE
//  Interrupt source for the MIPS core: collects NUM_SRC edge-triggered request lines and drives the core's irq / irq_addr inputs.
//  Latches events as pending bits and picks the highest-priority enabled one. Holds irq with that source's ISR vector until the core pulses irq_ack on ISR resume.
//  A small config port lets software write the enable mask and vector base and read or clear pending bits.
// PARAMETERS
//  NUM_SRC       4             number of request lines (1..16)
//  VEC_BASE_RST  32'h0000_0000 reset value of the vector base register
//  VEC_SHIFT     4             vector stride = 1<<VEC_SHIFT bytes per source
// PORTS
//  clk        in   1        system clock, all logic on rising edge
//  rst        in   1        synchronous, active-high reset
//  src        in   NUM_SRC  request lines, already in the clk domain; a 0->1 transition is one event
//  irq        out  1        to core irq
//  irq_addr   out  32       to core irq_addr, ISR address of the selected source
//  irq_ack    in   1        from core irq_ack, 1-cycle pulse when the core leaves the ISR
//  cfg_we     in   1        config write strobe
//  cfg_addr   in   2        0=ENABLE 1=VBASE 2=PENDING 3=STATUS
//  cfg_wd     in   32       config write data
//  cfg_rd     out  32       config read data, combinational on cfg_addr
// BEHAVIOUR
//  Reset values
//   - irq=0, irq_addr=0, enable=0, vbase=VEC_BASE_RST.
//   - pending=0, src_prev=0, cur_id=0, state=IDLE.
//  Edge detection
//   - rise[i] = src[i] & ~src_prev[i]; src_prev <= src every cycle.
//   - Only rise[i] & enable[i] sets pending[i]. Edges on disabled lines are dropped, not remembered.
//  Pending update precedence (per bit, same cycle)
//   - set by a new edge wins over a W1C clear and over an ack clear.
//   - pending <= (pending & ~clr) | (rise & enable).
//  Selection
//   - elig = pending & enable. sel_id = lowest index set in elig (index 0 is highest priority).
//  FSM
//   - IDLE: if elig!=0 then cur_id<=sel_id, irq_addr<=vbase + (sel_id<<VEC_SHIFT) (mod 2^32), irq<=1, go ACTIVE.
//   - ACTIVE: irq and irq_addr are held constant.
//     . New edges only set pending bits; there is no preemption.
//     . Clearing the enable bit of cur_id does not drop irq.
//     . On irq_ack: clear pending[cur_id] (unless a new edge on it arrives the same cycle), irq<=0, go GAP.
//   - GAP: exactly 1 cycle with irq=0 so the core sees the deassertion, then go IDLE.
//     . Earliest re-assertion is 2 cycles after the ack cycle.
//   - irq_ack in IDLE or GAP is ignored and has no side effects.
//  Latency
//   - rise at cycle N -> pending set at edge N+1 -> irq=1 visible after edge N+2.
//  Config writes (take effect at the next edge)
//   - ENABLE: enable <= cfg_wd[NUM_SRC-1:0]. Disabling a line keeps its pending bit but makes it ineligible.
//   - VBASE: vbase <= cfg_wd. Does not change irq_addr while ACTIVE.
//   - PENDING: write-1-to-clear. Clearing the pending bit of cur_id while ACTIVE does not drop irq; the later ack clear is then a no-op.
//   - STATUS: read-only; writes are ignored.
//  Config reads
//   - ENABLE, VBASE, PENDING: zero-extended register value.
//   - STATUS: {26'b0, state==ACTIVE, 1'b0, cur_id[3:0]}.
//  Reset mid-operation: returns to IDLE with irq=0 the next cycle; pending events are lost.
// TESTING
//  1. Reset, ENABLE=4'b0001, VBASE=32'h400, pulse src[0] -> irq=1 two cycles later, irq_addr=32'h400; ack -> irq=0, pending=0.
//  2. src[2] and src[1] rise in the same cycle, enable=4'hF, VEC_SHIFT=4 -> first irq_addr=vbase+32'h10; after ack and 1 GAP cycle, irq_addr=vbase+32'h20.
//  3. While ACTIVE on id 1, src[0] rises -> irq_addr unchanged; after ack, GAP, then irq_addr=vbase+0.
//  4. ENABLE=0, pulse src[3] -> pending stays 0 and irq stays 0; then ENABLE=4'h8 -> still no irq (edge was dropped).
//  5. irq_ack pulse in IDLE -> no change. Ack arrives in the same cycle as a new src[1] edge while serving id 1 -> pending[1] stays 1 and irq re-asserts after GAP.
//  6. Assert rst while ACTIVE -> irq=0, irq_addr=0, pending=0, STATUS=0 next cycle; VBASE=0xFFFF_FFF0 with id 1 -> irq_addr=32'h0000_0000 (wraps).

Source files
------------

// File: rtl/irq_controller_if.sv
// irq_controller_if
//   Bundles the interrupt request lines, the core-facing irq handshake and the
//   software config port of irq_controller.
//   master : the surrounding system (request sources, core, software bus)
//   slave  : irq_controller itself
//   src       NUM_SRC  request lines, 0->1 transition is one event
//   irq       1        interrupt request to the core
//   irq_addr  32       ISR vector of the selected source
//   irq_ack   1        1-cycle pulse from the core on ISR exit
//   cfg_we    1        config write strobe
//   cfg_addr  2        0=ENABLE 1=VBASE 2=PENDING 3=STATUS
//   cfg_wd    32       config write data
//   cfg_rd    32       config read data, combinational on cfg_addr
interface irq_controller_if #(
  parameter int NUM_SRC = 4
);
  logic [NUM_SRC-1:0] src;
  logic               irq;
  logic [31:0]        irq_addr;
  logic               irq_ack;
  logic               cfg_we;
  logic [1:0]         cfg_addr;
  logic [31:0]        cfg_wd;
  logic [31:0]        cfg_rd;

  modport master (
    output src, irq_ack, cfg_we, cfg_addr, cfg_wd,
    input  irq, irq_addr, cfg_rd
  );

  modport slave (
    input  src, irq_ack, cfg_we, cfg_addr, cfg_wd,
    output irq, irq_addr, cfg_rd
  );
endinterface

// File: rtl/irq_controller.sv
// irq_controller
//   Latches rising edges of enabled request lines as pending bits, picks the
//   lowest-index enabled pending source and holds irq with its ISR vector until
//   the core acknowledges. A one-cycle gap with irq low follows every ack.
//   clk   system clock, rising edge
//   rst   synchronous, active-high reset
//   bus   irq_controller_if.slave (request lines, core handshake, config port)
//
//   state  | meaning
//   IDLE   | no interrupt presented, waiting for an eligible pending source
//   ACTIVE | irq held high with irq_addr of cur_id until irq_ack
//   GAP    | one cycle of irq low after an ack so the core sees the drop
module irq_controller #(
  parameter int          NUM_SRC      = 4,
  parameter logic [31:0] VEC_BASE_RST = 32'h0000_0000,
  parameter int          VEC_SHIFT    = 4
) (
  input  logic             clk,
  input  logic             rst,
  irq_controller_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_t;

  localparam logic [1:0] A_ENABLE  = 2'd0;
  localparam logic [1:0] A_VBASE   = 2'd1;
  localparam logic [1:0] A_PENDING = 2'd2;
  localparam logic [1:0] A_STATUS  = 2'd3;

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [31:0]        vbase_q, vbase_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] src_prev_q, src_prev_d;
  logic [3:0]         cur_id_q, cur_id_d;
  logic [31:0]        irq_addr_q, irq_addr_d;

  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] elig;
  logic [NUM_SRC-1:0] w1c_mask;
  logic [NUM_SRC-1:0] ack_mask;
  logic [3:0]         sel_id;
  logic               ack_take;

  always_comb begin
    rise = bus.src & ~src_prev_q;
    elig = pending_q & enable_q;

    // Scan downwards so the lowest set index is the one left in sel_id.
    sel_id = 4'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (elig[i]) sel_id = 4'(i);
    end

    ack_take = (state_q == ACTIVE) && bus.irq_ack;
    ack_mask = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      ack_mask[i] = ack_take && (cur_id_q == 4'(i));
    end

    w1c_mask = '0;
    if (bus.cfg_we && bus.cfg_addr == A_PENDING) w1c_mask = bus.cfg_wd[NUM_SRC-1:0];
  end

  always_comb begin
    state_d    = state_q;
    enable_d   = enable_q;
    vbase_d    = vbase_q;
    cur_id_d   = cur_id_q;
    irq_addr_d = irq_addr_q;
    src_prev_d = bus.src;

    // A new edge wins over both clear sources in the same cycle.
    pending_d = (pending_q & ~(w1c_mask | ack_mask)) | (rise & enable_q);

    if (bus.cfg_we && bus.cfg_addr == A_ENABLE) enable_d = bus.cfg_wd[NUM_SRC-1:0];
    if (bus.cfg_we && bus.cfg_addr == A_VBASE)  vbase_d  = bus.cfg_wd;

    unique case (state_q)
      IDLE: begin
        if (elig != '0) begin
          cur_id_d   = sel_id;
          irq_addr_d = vbase_q + (32'(sel_id) << VEC_SHIFT);
          state_d    = ACTIVE;
        end
      end
      ACTIVE: begin
        if (bus.irq_ack) state_d = GAP;
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      enable_q   <= '0;
      vbase_q    <= VEC_BASE_RST;
      pending_q  <= '0;
      src_prev_q <= '0;
      cur_id_q   <= 4'd0;
      irq_addr_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      enable_q   <= enable_d;
      vbase_q    <= vbase_d;
      pending_q  <= pending_d;
      src_prev_q <= src_prev_d;
      cur_id_q   <= cur_id_d;
      irq_addr_q <= irq_addr_d;
    end
  end

  assign bus.irq      = (state_q == ACTIVE);
  assign bus.irq_addr = irq_addr_q;

  always_comb begin
    bus.cfg_rd = 32'd0;
    unique case (bus.cfg_addr)
      A_ENABLE:  bus.cfg_rd = 32'(enable_q);
      A_VBASE:   bus.cfg_rd = vbase_q;
      A_PENDING: bus.cfg_rd = 32'(pending_q);
      A_STATUS:  bus.cfg_rd = {26'd0, state_q == ACTIVE, 1'b0, cur_id_q};
      default:   bus.cfg_rd = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_irq_controller.sv
module tb_irq_controller;

  localparam logic [1:0] A_ENABLE  = 2'd0;
  localparam logic [1:0] A_VBASE   = 2'd1;
  localparam logic [1:0] A_PENDING = 2'd2;
  localparam logic [1:0] A_STATUS  = 2'd3;

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;

  irq_controller_if #(.NUM_SRC(4)) bus ();

  irq_controller #(
    .NUM_SRC      (4),
    .VEC_BASE_RST (32'h0000_0000),
    .VEC_SHIFT    (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = a;
    bus.cfg_wd   = d;
    tick();
    bus.cfg_we   = 1'b0;
    bus.cfg_wd   = 32'd0;
  endtask

  task automatic cfg_read(input logic [1:0] a, output logic [31:0] d);
    bus.cfg_addr = a;
    #1;
    d = bus.cfg_rd;
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    cfg_read(a, d);
    chk(tag, d, exp);
  endtask

  // One-cycle high pulse on the selected lines: the edge is seen at the next clock.
  task automatic pulse(input logic [3:0] m);
    bus.src = bus.src | m;
    tick();
    bus.src = bus.src & ~m;
  endtask

  task automatic ack();
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
  endtask

  initial begin
    n_total      = 0;
    n_pass       = 0;
    rst          = 1'b1;
    bus.src      = '0;
    bus.irq_ack  = 1'b0;
    bus.cfg_we   = 1'b0;
    bus.cfg_addr = 2'd0;
    bus.cfg_wd   = 32'd0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // reset state
    chk("rst_irq", 32'(bus.irq), 32'd0);
    chk("rst_addr", bus.irq_addr, 32'd0);
    chk_reg("rst_enable", A_ENABLE, 32'd0);
    chk_reg("rst_vbase", A_VBASE, 32'd0);
    chk_reg("rst_pending", A_PENDING, 32'd0);
    chk_reg("rst_status", A_STATUS, 32'd0);

    // 1: single source, latency and ack
    cfg_write(A_ENABLE, 32'h1);
    cfg_write(A_VBASE, 32'h400);
    pulse(4'b0001);
    chk("t1_irq_early", 32'(bus.irq), 32'd0);
    chk_reg("t1_pend_set", A_PENDING, 32'h1);
    tick();
    chk("t1_irq", 32'(bus.irq), 32'd1);
    chk("t1_addr", bus.irq_addr, 32'h400);
    chk_reg("t1_status", A_STATUS, 32'h20);
    ack();
    chk("t1_irq_ack", 32'(bus.irq), 32'd0);
    chk_reg("t1_pend_clr", A_PENDING, 32'h0);
    chk_reg("t1_status_gap", A_STATUS, 32'h0);
    tick();

    // 2: simultaneous edges, priority and gap
    cfg_write(A_ENABLE, 32'hF);
    pulse(4'b0110);
    tick();
    chk("t2_irq1", 32'(bus.irq), 32'd1);
    chk("t2_addr1", bus.irq_addr, 32'h410);
    chk_reg("t2_status1", A_STATUS, 32'h21);
    chk_reg("t2_pend", A_PENDING, 32'h6);
    ack();
    chk("t2_gap_irq", 32'(bus.irq), 32'd0);
    chk_reg("t2_pend_after", A_PENDING, 32'h4);
    tick();
    chk("t2_idle_irq", 32'(bus.irq), 32'd0);
    tick();
    chk("t2_irq2", 32'(bus.irq), 32'd1);
    chk("t2_addr2", bus.irq_addr, 32'h420);
    ack();
    tick();
    tick();
    chk("t2_done_irq", 32'(bus.irq), 32'd0);

    // 3: no preemption, config changes while ACTIVE
    pulse(4'b0010);
    tick();
    chk("t3_addr1", bus.irq_addr, 32'h410);
    pulse(4'b0001);
    chk("t3_addr_hold", bus.irq_addr, 32'h410);
    chk_reg("t3_pend", A_PENDING, 32'h3);
    cfg_write(A_VBASE, 32'h800);
    chk("t3_vbase_hold", bus.irq_addr, 32'h410);
    cfg_write(A_ENABLE, 32'hD);
    chk("t3_dis_hold", 32'(bus.irq), 32'd1);
    cfg_write(A_ENABLE, 32'hF);
    ack();
    chk("t3_ack_irq", 32'(bus.irq), 32'd0);
    chk_reg("t3_pend_ack", A_PENDING, 32'h1);
    tick();
    tick();
    chk("t3_irq0", 32'(bus.irq), 32'd1);
    chk("t3_addr0", bus.irq_addr, 32'h800);
    cfg_write(A_PENDING, 32'h1);
    chk_reg("t3_w1c", A_PENDING, 32'h0);
    chk("t3_w1c_hold", 32'(bus.irq), 32'd1);
    ack();
    tick();
    tick();
    chk("t3_idle", 32'(bus.irq), 32'd0);
    cfg_write(A_VBASE, 32'h400);

    // 4: edges on disabled lines are dropped; STATUS is read-only
    cfg_write(A_ENABLE, 32'h0);
    pulse(4'b1000);
    chk_reg("t4_pend", A_PENDING, 32'h0);
    cfg_write(A_ENABLE, 32'h8);
    tick();
    tick();
    chk("t4_irq", 32'(bus.irq), 32'd0);
    chk_reg("t4_pend2", A_PENDING, 32'h0);
    cfg_write(A_STATUS, 32'hFFFF_FFFF);
    chk_reg("t4_status_ro", A_STATUS, 32'h0);

    // 5: ack in IDLE ignored; ack coinciding with a new edge on cur_id
    ack();
    tick();
    chk("t5_idle_ack_irq", 32'(bus.irq), 32'd0);
    chk_reg("t5_idle_ack_pend", A_PENDING, 32'h0);
    cfg_write(A_ENABLE, 32'hF);
    pulse(4'b0010);
    tick();
    chk("t5_irq", 32'(bus.irq), 32'd1);
    bus.src     = 4'b0010;
    bus.irq_ack = 1'b1;
    tick();
    bus.src     = 4'b0000;
    bus.irq_ack = 1'b0;
    chk("t5_ack_irq", 32'(bus.irq), 32'd0);
    chk_reg("t5_pend_kept", A_PENDING, 32'h2);
    tick();
    tick();
    chk("t5_reassert", 32'(bus.irq), 32'd1);
    chk("t5_addr", bus.irq_addr, 32'h410);

    // 6: reset while ACTIVE, then vector wraparound
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_irq", 32'(bus.irq), 32'd0);
    chk("t6_addr", bus.irq_addr, 32'd0);
    chk_reg("t6_pend", A_PENDING, 32'h0);
    chk_reg("t6_status", A_STATUS, 32'h0);
    chk_reg("t6_enable", A_ENABLE, 32'h0);
    cfg_write(A_ENABLE, 32'hF);
    cfg_write(A_VBASE, 32'hFFFF_FFF0);
    pulse(4'b0010);
    tick();
    chk("t6_wrap_irq", 32'(bus.irq), 32'd1);
    chk("t6_wrap_addr", bus.irq_addr, 32'h0000_0000);
    chk_reg("t6_wrap_status", A_STATUS, 32'h21);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
